// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter between instruction fetch and data access.
// One transaction outstanding at a time: capture in IDLE, present to memory
// in ISSUE, collect the response in WAIT and hand it back to the owner.
// Data wins arbitration unless fetch has lost STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,

  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wmask_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_ready_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                stall_if_o,
  output logic                stall_d_o,
  output logic                err_o
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam logic [3:0]  StarveLimit = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
  typedef enum logic {OwnFetch, OwnData} owner_e;

  state_e              state_q;
  owner_e              owner_q;
  logic [3:0]          starve_q;
  logic                err_q;
  logic                if_gnt_q, d_gnt_q;
  logic                if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MaskW-1:0]    mem_wmask_q;
  logic                pick_fetch;
  logic                fetch_busy, data_busy;

  // Fetch wins when alone, or when it has been starved for the full limit.
  always_comb begin
    pick_fetch = if_req_i & (~d_req_i | (starve_q == StarveLimit));
  end

  // Control FSM plus every registered output and memory request field.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      owner_q     <= OwnFetch;
      starve_q    <= '0;
      err_q       <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      // A response with nothing in flight means the memory side is confused.
      if (mem_rvalid_i && (state_q != StWait)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (!if_req_i) begin
            starve_q <= '0;
          end
          if (if_req_i || d_req_i) begin
            state_q   <= StIssue;
            mem_req_q <= 1'b1;
            if (pick_fetch) begin
              owner_q     <= OwnFetch;
              if_gnt_q    <= 1'b1;
              starve_q    <= '0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr_i;
              mem_wdata_q <= '0;
              mem_wmask_q <= '0;
            end else begin
              owner_q     <= OwnData;
              d_gnt_q     <= 1'b1;
              mem_we_q    <= d_we_i;
              mem_addr_q  <= d_addr_i;
              mem_wdata_q <= d_wdata_i;
              mem_wmask_q <= d_wmask_i;
              if (if_req_i && (starve_q != StarveLimit)) begin
                starve_q <= starve_q + 4'd1;
              end
            end
          end
        end
        StIssue: begin
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_rvalid_i) begin
            state_q <= StIdle;
            if (owner_q == OwnFetch) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata_i;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_we_q ? '0 : mem_rdata_i;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stalls are combinational so the pipeline freezes in the request cycle.
  always_comb begin
    fetch_busy = (state_q != StIdle) && (owner_q == OwnFetch);
    data_busy  = (state_q != StIdle) && (owner_q == OwnData);
    stall_if_o = (if_req_i | fetch_busy) & ~if_rvalid_q;
    stall_d_o  = (d_req_i | data_busy) & ~d_rvalid_q;
  end

  assign if_gnt_o    = if_gnt_q;
  assign d_gnt_o     = d_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed reset/error scenarios, a randomized
// phase against a transaction-schedule model, and a grant-order phase.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_wmask_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o, stall_d_o, err_o;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_wmask_i   (d_wmask_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_ready_i (mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_if_o  (stall_if_o),
    .stall_d_o   (stall_d_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction schedule: every event of the current transaction is a cycle number.
  int          cyc, free_at, gnt_cyc, acc_cyc, resp_cyc, rv_cyc;
  bit          own_f, ex_we, if_pend, d_pend;
  logic [31:0] ex_addr, ex_wdata, ex_rdata, raw_rdata;
  logic [3:0]  ex_wmask;
  int          losses;
  int          p_if, p_d, max_r, max_v;
  logic [31:0] mem_a [256];
  bit          gq[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    if_req_i = 0; if_addr_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_wmask_i = 0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic reset_dut();
    rst_ni = 0;
    clear_inputs();
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic model_reset();
    cyc = 0; free_at = 0;
    gnt_cyc = -100; acc_cyc = -100; resp_cyc = -100; rv_cyc = -100;
    own_f = 1; losses = 0; if_pend = 0; d_pend = 0;
    gq.delete();
  endtask

  // One cycle: check registered outputs, drive requesters and memory, check
  // stalls, then let the model arbitrate if the port is free.
  task automatic step();
    bit e_ig, e_dg, e_mreq, e_irv, e_drv, e_fout, e_dout;
    int idx;
    e_ig   = (cyc == gnt_cyc) && own_f;
    e_dg   = (cyc == gnt_cyc) && !own_f;
    e_mreq = (cyc >= gnt_cyc) && (cyc <= acc_cyc);
    e_irv  = (cyc == rv_cyc) && own_f;
    e_drv  = (cyc == rv_cyc) && !own_f;
    e_fout = (cyc >= gnt_cyc) && (cyc < rv_cyc) && own_f;
    e_dout = (cyc >= gnt_cyc) && (cyc < rv_cyc) && !own_f;

    if (if_gnt_o) gq.push_back(1'b1);
    if (d_gnt_o)  gq.push_back(1'b0);
    check_eq("if_gnt", if_gnt_o, e_ig);
    check_eq("d_gnt", d_gnt_o, e_dg);
    check_eq("mem_req", mem_req_o, e_mreq);
    if (e_mreq) begin
      check_eq("mem_addr", mem_addr_o, ex_addr);
      check_eq("mem_we", mem_we_o, ex_we);
      if (!own_f) begin
        check_eq("mem_wdata", mem_wdata_o, ex_wdata);
        check_eq("mem_wmask", mem_wmask_o, ex_wmask);
      end
    end
    check_eq("if_rvalid", if_rvalid_o, e_irv);
    check_eq("d_rvalid", d_rvalid_o, e_drv);
    if (e_irv) check_eq("if_rdata", if_rdata_o, ex_rdata);
    if (e_drv) check_eq("d_rdata", d_rdata_o, ex_rdata);
    check_eq("err", err_o, 0);

    if (e_ig) if_pend = 0;
    if (e_dg) d_pend = 0;
    if (!if_pend && ($urandom_range(99) < p_if)) begin
      if_pend   = 1;
      if_addr_i = 32'($urandom_range(255)) << 2;
    end
    if (!d_pend && ($urandom_range(99) < p_d)) begin
      d_pend    = 1;
      d_we_i    = 1'($urandom_range(1));
      d_addr_i  = 32'($urandom_range(255)) << 2;
      d_wdata_i = $urandom;
      d_wmask_i = 4'($urandom_range(15));
    end
    if_req_i     = if_pend;
    d_req_i      = d_pend;
    // Ready outside the issue window must be ignored, so sprinkle some in.
    mem_ready_i  = (cyc == acc_cyc) ||
                   (((cyc < gnt_cyc) || (cyc > acc_cyc)) && ($urandom_range(1) == 1));
    mem_rvalid_i = (cyc == resp_cyc);
    mem_rdata_i  = (cyc == resp_cyc) ? raw_rdata : $urandom;
    #1;
    check_eq("stall_if", stall_if_o, (if_req_i | e_fout) & ~e_irv);
    check_eq("stall_d", stall_d_o, (d_req_i | e_dout) & ~e_drv);

    if (cyc >= free_at) begin
      if (!if_req_i) losses = 0;
      if (if_req_i || d_req_i) begin
        own_f = if_req_i && (!d_req_i || (losses == STARVE));
        if (own_f) losses = 0;
        else if (if_req_i && (losses < STARVE)) losses++;
        gnt_cyc  = cyc + 1;
        acc_cyc  = gnt_cyc + $urandom_range(max_r);
        resp_cyc = acc_cyc + 1 + $urandom_range(max_v);
        rv_cyc   = resp_cyc + 1;
        free_at  = rv_cyc;
        if (own_f) begin
          ex_addr   = if_addr_i;
          ex_we     = 0;
          idx       = int'(ex_addr[9:2]);
          raw_rdata = mem_a[idx];
          ex_rdata  = raw_rdata;
        end else begin
          ex_addr  = d_addr_i;
          ex_we    = d_we_i;
          ex_wdata = d_wdata_i;
          ex_wmask = d_wmask_i;
          idx      = int'(ex_addr[9:2]);
          if (ex_we) begin
            for (int b = 0; b < 4; b++)
              if (ex_wmask[b]) mem_a[idx][8*b +: 8] = ex_wdata[8*b +: 8];
            raw_rdata = $urandom;
            ex_rdata  = 0;
          end else begin
            raw_rdata = mem_a[idx];
            ex_rdata  = raw_rdata;
          end
        end
      end
    end
    cyc++;
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 0;
    clear_inputs();
    cyc = 0;
    for (int i = 0; i < 256; i++) mem_a[i] = $urandom;

    // Reset held two cycles in the middle of a WAIT.
    reset_dut();
    d_req_i = 1; d_addr_i = 32'h80; mem_ready_i = 1;
    @(negedge clk_i);
    check_eq("a_d_gnt", d_gnt_o, 1);
    check_eq("a_mem_req", mem_req_o, 1);
    d_req_i = 0;
    @(negedge clk_i);
    check_eq("a_wait_mem_req", mem_req_o, 0);
    rst_ni = 0;
    mem_ready_i = 0;
    repeat (2) @(negedge clk_i);
    check_eq("a_rst_ctl", {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o,
                           err_o, stall_if_o, stall_d_o}, 0);
    check_eq("a_rst_addr", mem_addr_o, 0);
    check_eq("a_rst_wd", {mem_wdata_o, mem_wmask_o}, 0);
    check_eq("a_rst_rdata", {if_rdata_o, d_rdata_o}, 0);
    // First fetch after reset, zero-wait memory: three cycles to rvalid.
    rst_ni = 1;
    if_req_i = 1; if_addr_i = 32'h40; mem_ready_i = 1;
    @(negedge clk_i);
    check_eq("a_if_gnt", if_gnt_o, 1);
    check_eq("a_if_mem_req", mem_req_o, 1);
    check_eq("a_if_mem_addr", mem_addr_o, 32'h40);
    if_req_i = 0;
    @(negedge clk_i);
    check_eq("a_if_rvalid_early", if_rvalid_o, 0);
    check_eq("a_stall_if_wait", stall_if_o, 1);
    mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
    @(negedge clk_i);
    mem_rvalid_i = 0;
    check_eq("a_if_rvalid", if_rvalid_o, 1);
    check_eq("a_if_rdata", if_rdata_o, 32'h00500093);
    check_eq("a_d_rvalid", d_rvalid_o, 0);
    @(negedge clk_i);
    check_eq("a_if_rvalid_end", if_rvalid_o, 0);
    check_eq("a_stall_if_end", stall_if_o, 0);
    check_eq("a_err", err_o, 0);

    // Load interrupted by a one-cycle reset; late response lands in IDLE.
    reset_dut();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100; mem_ready_i = 1;
    @(negedge clk_i);
    check_eq("b_d_gnt", d_gnt_o, 1);
    d_req_i = 0;
    @(negedge clk_i);
    rst_ni = 0;
    @(negedge clk_i);
    rst_ni = 1;
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    mem_rvalid_i = 0;
    for (int i = 0; i < 4; i++) begin
      check_eq("b_err", err_o, 1);
      check_eq("b_rvalid", {if_rvalid_o, d_rvalid_o}, 0);
      @(negedge clk_i);
    end

    // Randomized traffic with memory wait states.
    reset_dut();
    model_reset();
    p_if = 40; p_d = 50; max_r = 3; max_v = 3;
    for (int i = 0; i < 2500; i++) step();

    // Both requesters always asking, zero-wait memory: fetch wins every fifth.
    reset_dut();
    model_reset();
    p_if = 100; p_d = 100; max_r = 0; max_v = 0;
    for (int i = 0; i < 45; i++) step();
    check_eq("gnt_count", (gq.size() >= 10), 1);
    if (gq.size() >= 10)
      for (int i = 0; i < 10; i++) check_eq("gnt_order", gq[i], ((i % 5) == 4));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
